cmul_sequencer: RTL
===================

# cmul_sequencer

Sequencing controller that computes one signed complex product (sample × twiddle) for the radix-4 FFT butterfly by time-sharing a single unsigned radix-4 Booth `Multiplier` instance over four cycles. It converts signed operands to sign-magnitude form, issues the four real partial products in a fixed order and accumulates them into real and imaginary results. Upstream and downstream connect through valid/ready handshakes. It sits between the twiddle ROM/sample buffer and the butterfly adders.

## Interface
- `N`, default 8: operand width. Two's complement, must be even and ≥ 4.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: operand set valid.
- `in_ready` output, 1 bit: block can accept an operand set.
- `a_re`, `a_im` input, N bits each: sample, signed.
- `w_re`, `w_im` input, N bits each: twiddle, signed.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: downstream accepts the result.
- `p_re`, `p_im` output, 2N+1 bits each: signed result.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - MUL0..MUL3: one product per state.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→MUL0 on `in_valid && in_ready`. All four operands are latched on the same edge.
  - MULk→MUL(k+1) unconditionally; MUL3→DONE.
  - DONE→IDLE on `out_ready`. DONE holds while `out_ready`=0.
- A new input is never accepted in DONE. `in_ready` is registered state, not a combinational path from `out_ready`.
- Product order (x = multiplicand, y = multiplier):
  - MUL0: a_re·w_re
  - MUL1: a_im·w_re
  - MUL2: a_im·w_im
  - MUL3: a_re·w_im
- Sign-magnitude conversion:
  - Each operand goes to the shared unsigned multiplier as |v|, N bits. |−2^(N−1)| = 2^(N−1) fits unsigned.
  - Product sign = sign(x) XOR sign(y). The signed product is the 2N-bit magnitude zero-extended to 2N+1 bits and conditionally negated.
  - A zero magnitude yields 0 regardless of sign.
- Accumulators (`acc_re`, `acc_im`, 2N+1 bits, signed):
  - MUL0: `acc_re` ← +p
  - MUL1: `acc_im` ← +p
  - MUL2: `acc_re` ← `acc_re` − p
  - MUL3: `acc_im` ← `acc_im` + p
- No overflow is possible: the maximum magnitude is 2^(2N−1), which fits in 2N+1 bits signed. No saturation or rounding.
- `p_re`/`p_im` are driven directly from the accumulators. They are stable throughout DONE.
- Multiplier operand muxes select from the latched operand registers only, never from the live inputs.
- Reset values: state=IDLE, `in_ready`=1 (combinational from state), `out_valid`=0, `busy`=0, `p_re`=`p_im`=0, operand registers 0.
- Reset mid-operation aborts immediately. The partial result is discarded and no `out_valid` pulse follows.

## Timing
- Handshake at cycle T (IDLE, `in_valid`=1).
- MUL0..MUL3 occupy cycles T+1..T+4.
- `out_valid`=1 from cycle T+5. Latency is 5 cycles.
- With `out_ready` held high, `out_valid` lasts one cycle, IDLE is at T+6 and the next accept is at T+6. Maximum throughput is 1 result per 6 cycles.
- All outputs are registered or decoded from registered state. There is no input-to-output combinational path.
- `in_valid` may drop in any cycle without side effects. Operand values outside the accept cycle are ignored.

## Configuration
- Macro: `CMUL_ZERO_SKIP_EN`.
- Defined:
  - If the latched `w_im` equals 0, MUL1 goes directly to DONE. MUL2 and MUL3 are skipped because their products are zero.
  - The result becomes (a_re·w_re, a_im·w_re), with `out_valid` at T+3.
  - Trivial twiddles (W⁰, and W^{N/2} in general) take 3 cycles instead of 5.
- Undefined: all operand sets take the full 4 MUL states. Latency is fixed at 5.

## Test plan
1. N=8, a=(3,4), w=(5,−2) accepted at T → `out_valid` at T+5 with p_re=23, p_im=14; IDLE at T+6.
2. Extremes: a=(−128,−128), w=(−128,−128) → p_re=0, p_im=32768 (17-bit, no overflow).
3. Backpressure: case 1 with `out_ready`=0 for 7 cycles → `out_valid` and p_re/p_im stay at 23/14 and `in_ready`=0 throughout; `out_ready`=1 → IDLE on the next cycle.
4. Reset mid-op: assert `rst` asynchronously during MUL2 → `busy`, `out_valid`, p_re, p_im read 0 immediately. After release, case 1 completes with exactly 5-cycle latency.
5. Zero magnitude/sign: a=(0,−1), w=(−7,0) → p_re=0, p_im=7. With `CMUL_ZERO_SKIP_EN`, `out_valid` at T+3; without it, at T+5.
6. Back-to-back: `in_valid` held high with 3 operand sets and `out_ready`=1 → exactly 3 results, accepts spaced 6 cycles apart, and no set duplicated or dropped.

Source files
------------

// File: rtl/cmul_sequencer.sv
// cmul_sequencer: signed complex product (a * w) using one shared unsigned radix-4 Booth
// multiplier over four cycles. Optional CMUL_ZERO_SKIP_EN: finish after MUL1 when latched w_im is zero.

module Multiplier #(
    parameter int N = 8
) (
    input  logic [N-1:0]   x_i,
    input  logic [N-1:0]   y_i,
    output logic [2*N-1:0] p_o
);
    localparam int unsigned NDIG = N / 2 + 1;

    logic [N+2:0]   yz;
    logic [2*N-1:0] xe;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc;
    logic [2:0]     trip;

    // Two leading zeros keep the top Booth digit non-negative for unsigned y
    always_comb begin
        yz   = {2'b00, y_i, 1'b0};
        xe   = {{N{1'b0}}, x_i};
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int unsigned k = 0; k < NDIG; k++) begin
            trip = yz[2*k +: 3];
            case (trip)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * k));
        end
        p_o = acc;
    end
endmodule

module cmul_sequencer #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a_re,
    input  logic [N-1:0]   a_im,
    input  logic [N-1:0]   w_re,
    input  logic [N-1:0]   w_im,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N:0]   p_re,
    output logic [2*N:0]   p_im,
    output logic           busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL0,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   are_q, aim_q, wre_q, wim_q;
    logic [N-1:0]   are_d, aim_d, wre_d, wim_d;
    logic [2*N:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;

    logic [N-1:0]   x_sel, y_sel, x_mag, y_mag;
    logic [2*N-1:0] mag_prod;
    logic [2*N:0]   prod;
    logic           prod_neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            are_q    <= '0;
            aim_q    <= '0;
            wre_q    <= '0;
            wim_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            state_q  <= state_d;
            are_q    <= are_d;
            aim_q    <= aim_d;
            wre_q    <= wre_d;
            wim_q    <= wim_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
        end
    end

    // Operand selection from latched registers only; sign-magnitude conversion around the unsigned core
    always_comb begin
        x_sel = '0;
        y_sel = '0;
        case (state_q)
            S_MUL0: begin x_sel = are_q; y_sel = wre_q; end
            S_MUL1: begin x_sel = aim_q; y_sel = wre_q; end
            S_MUL2: begin x_sel = aim_q; y_sel = wim_q; end
            S_MUL3: begin x_sel = are_q; y_sel = wim_q; end
            default: ;
        endcase
        x_mag    = x_sel[N-1] ? -x_sel : x_sel;
        y_mag    = y_sel[N-1] ? -y_sel : y_sel;
        prod_neg = x_sel[N-1] ^ y_sel[N-1];
        prod     = prod_neg ? -{1'b0, mag_prod} : {1'b0, mag_prod};
    end

    Multiplier #(.N(N)) u_mult (
        .x_i (x_mag),
        .y_i (y_mag),
        .p_o (mag_prod)
    );

    always_comb begin
        state_d   = state_q;
        are_d     = are_q;
        aim_d     = aim_q;
        wre_d     = wre_q;
        wim_d     = wim_q;
        acc_re_d  = acc_re_q;
        acc_im_d  = acc_im_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    are_d   = a_re;
                    aim_d   = a_im;
                    wre_d   = w_re;
                    wim_d   = w_im;
                    state_d = S_MUL0;
                end
            end
            S_MUL0: begin
                acc_re_d = prod;
                state_d  = S_MUL1;
            end
            S_MUL1: begin
                acc_im_d = prod;
`ifdef CMUL_ZERO_SKIP_EN
                state_d  = (wim_q == '0) ? S_DONE : S_MUL2;
`else
                state_d  = S_MUL2;
`endif
            end
            S_MUL2: begin
                acc_re_d = acc_re_q - prod;
                state_d  = S_MUL3;
            end
            S_MUL3: begin
                acc_im_d = acc_im_q + prod;
                state_d  = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign p_re = acc_re_q;
    assign p_im = acc_im_q;
endmodule
